// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule definitions.
//   - aes_mode_e  : key-size selector (AES128/AES192/AES256; encoding 3 is illegal)
//   - state_e     : key-expansion FSM states (IDLE, EMIT, FIN)
//   - nk_of/nr_of : key length in words / round count for a mode
//   - key_bits_of : key size in bits for a mode (0 for the illegal encoding)
//   - SBOX        : forward AES S-box, 256 x 8
//   - xtime, rot_word, sub_word : GF(2^8) doubling and word helpers
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'd0,
    AES192 = 2'd1,
    AES256 = 2'd2
  } aes_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES128:  return 4'(NK_128);
      AES192:  return 4'(NK_192);
      default: return 4'(NK_256);
    endcase
  endfunction

  function automatic int nr_of(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES128:  return NR_128;
      AES192:  return NR_192;
      default: return NR_256;
    endcase
  endfunction

  function automatic int key_bits_of(input logic [1:0] mode);
    case (aes_mode_e'(mode))
      AES128:  return 128;
      AES192:  return 192;
      AES256:  return 256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational AES SubWord, four parallel S-box lookups.
//   data_i [31:0] : input word
//   data_o [31:0] : S-box applied to each byte of data_i
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign data_o[8*gi +: 8] = SBOX[data_i[8*gi +: 8]];
    end
  endgenerate

endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: sequential AES-128/192/256 key schedule, streaming one
// 32-bit word per cycle with valid/ready handshake.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, mode, key  : launch request, key size select (0/1/2), left-aligned key
//   busy, err         : run in progress, one-cycle pulse on a rejected start
//   word_valid/ready  : stream handshake; word_data/word_idx carry w[i] and i
//   done              : one-cycle pulse after the last word is accepted
//   rd_addr, rd_data  : schedule store read port (1-cycle latency)
// Build option: AES_KEY_STORE_EN adds a 60x32 store of every accepted word;
// without it rd_data is constant 0.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int IDX_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [255:0]     key,
  output logic             busy,
  output logic             err,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [31:0]      word_data,
  output logic [IDX_W-1:0] word_idx,
  output logic             done,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  state_e           state_q, state_d;
  logic [31:0]      win_q [8];
  logic [31:0]      win_d [8];
  logic [31:0]      word_q, word_d;
  logic [IDX_W-1:0] idx_q, last_q, idx_nx;
  logic [3:0]       nk_q;
  logic [2:0]       mod_q, mod_nx;
  logic [7:0]       rc_q;
  logic             err_q;
  logic             mode_legal, start_ok, accept, key_next, mod_wrap;
  logic [31:0]      sub_in, sub_out, temp;

  assign mode_legal = (mode != 2'd3) && (key_bits_of(mode) <= MAX_KEY_BITS);
  assign start_ok   = (state_q == ST_IDLE) && start && mode_legal;
  assign accept     = word_valid && word_ready;

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    word_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: if (start && mode_legal) state_d = ST_EMIT;
      ST_EMIT: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        if (word_ready && (idx_q == last_q)) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next word w[i+1] is computed from the current output w[i] and the window.
  // During the key phase the window still holds the raw key words; once the
  // schedule proper begins, win_q[0] is w[i+1-Nk] and the window slides by one.
  assign idx_nx   = idx_q + 1'b1;
  assign key_next = idx_nx < IDX_W'(nk_q);
  assign mod_wrap = ({1'b0, mod_q} == nk_q - 4'd1);
  assign mod_nx   = mod_wrap ? 3'd0 : mod_q + 3'd1;
  assign sub_in   = (mod_nx == 3'd0) ? rot_word(word_q) : word_q;

  aes_sub_word u_sub_word (
    .data_i (sub_in),
    .data_o (sub_out)
  );

  always_comb begin
    temp = word_q;
    if (mod_nx == 3'd0)
      temp = sub_out ^ {rc_q, 24'h0};
    else if ((nk_q == 4'd8) && (mod_nx == 3'd4))
      temp = sub_out;
    word_d = key_next ? win_q[idx_nx[2:0]] : (win_q[0] ^ temp);
  end

  // Shift the window down and insert the new word at slot Nk-1. Slots above
  // Nk-1 hold stale data that is never read for that key size.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_win
      if (gi < 7) begin : g_mid
        assign win_d[gi] = (nk_q == 4'(gi + 1)) ? word_d : win_q[gi + 1];
      end else begin : g_top
        assign win_d[gi] = word_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      nk_q    <= '0;
      mod_q   <= '0;
      rc_q    <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == ST_IDLE) && start && !mode_legal;
      if (start_ok) begin
        for (int k = 0; k < 8; k++) win_q[k] <= key[255 - 32*k -: 32];
        word_q <= key[255:224];
        idx_q  <= '0;
        mod_q  <= '0;
        rc_q   <= 8'h01;
        nk_q   <= nk_of(mode);
        last_q <= IDX_W'(4 * (nr_of(mode) + 1) - 1);
      end else if (accept && (idx_q != last_q)) begin
        word_q <= word_d;
        idx_q  <= idx_nx;
        mod_q  <= mod_nx;
        if (!key_next) begin
          for (int k = 0; k < 8; k++) win_q[k] <= win_d[k];
          if (mod_nx == 3'd0) rc_q <= xtime(rc_q);
        end
      end
    end
  end

  assign err       = err_q;
  assign word_data = word_q;
  assign word_idx  = idx_q;

`ifdef AES_KEY_STORE_EN
  localparam int STORE_DEPTH = 60;
  logic [31:0] store_q [STORE_DEPTH];
  logic [31:0] rd_data_q;

  // Write and read in the same process order: a same-cycle read of the
  // address being written returns the previous contents.
  always_ff @(posedge clk) begin
    if (accept) store_q[idx_q] <= word_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data_q <= '0;
    else
      rd_data_q <= (rd_addr < IDX_W'(STORE_DEPTH)) ? store_q[rd_addr] : '0;
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Testbench for aes_key_expand_seq: FIPS-197 table vectors, random keys and
// random backpressure checked against an arithmetic key-schedule model whose
// S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;

  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             start128 = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [1:0]       mode128 = 2'd0;
  logic [255:0]     key = '0;
  logic             word_ready = 1'b0;
  logic             r128 = 1'b1;
  logic [IDX_W-1:0] rd_addr = '0;

  logic             busy, err, word_valid, done;
  logic [31:0]      word_data, rd_data;
  logic [IDX_W-1:0] word_idx;
  logic             busy128, err128, wv128, done128;
  logic [31:0]      wd128, rd128;
  logic [IDX_W-1:0] wi128;

  int total = 0;
  int bad   = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] ref_w  [60];
  logic [31:0] cap_w  [60];

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    int           n;
    int           ia;
    logic [31:0]  ea;
    int           ib;
    logic [31:0]  eb;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  aes_key_expand_seq #(.MAX_KEY_BITS(256), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
    .busy(busy), .err(err), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_idx(word_idx), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  aes_key_expand_seq #(.MAX_KEY_BITS(128), .IDX_W(IDX_W)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .mode(mode128), .key(key),
    .busy(busy128), .err(err128), .word_valid(wv128), .word_ready(r128),
    .word_data(wd128), .word_idx(wi128), .done(done128),
    .rd_addr(rd_addr), .rd_data(rd128)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_ref(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Straight from the schedule definition: w[i] = w[i-Nk] ^ f(w[i-1]).
  task automatic expand_ref(input logic [1:0] m, input logic [255:0] k, output int n);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * int'(m);
    n  = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < n; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = sub_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_ref(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  // Starts a run, consumes the whole stream (ready low with probability
  // stall_pct %), and checks every word, stall stability, done and busy.
  task automatic run_expand(input logic [1:0] m, input logic [255:0] k, input int stall_pct,
                            input bit poke, input string tag, output int words);
    int n, got, cyc;
    logic held, err_seen, done_seen;
    logic [31:0] held_d;
    logic [IDX_W-1:0] held_i;
    expand_ref(m, k, n);
    mode = m; key = k; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy_start"}, busy, 1);
    got = 0; cyc = 0; held = 0; err_seen = 0; done_seen = 0;
    held_d = '0; held_i = '0;
    while (got < n && cyc < 400) begin
      err_seen  = err_seen | err;
      done_seen = done_seen | done;
      if (held) begin
        check($sformatf("%s stall_data[%0d]", tag, got), word_data, held_d);
        check($sformatf("%s stall_idx[%0d]", tag, got), word_idx, held_i);
      end
      if (poke && cyc == 5) begin
        start = 1'b1; mode = 2'd2; key = ~k;
      end else if (poke && cyc == 6) begin
        start = 1'b0; mode = m; key = k;
      end
      word_ready = ($urandom_range(0, 99) >= stall_pct);
      held = 0;
      if (word_valid) begin
        if (word_ready) begin
          check($sformatf("%s w[%0d]", tag, got), word_data, ref_w[got]);
          check($sformatf("%s idx[%0d]", tag, got), word_idx, got);
          cap_w[got] = word_data;
          got++;
        end else begin
          held = 1; held_d = word_data; held_i = word_idx;
        end
      end
      step();
      cyc++;
    end
    word_ready = 1'b0;
    words = got;
    check({tag, " all_words_in_budget"}, got, n);
    check({tag, " done_pulse"}, done, 1);
    check({tag, " busy_fin"}, busy, 0);
    check({tag, " valid_fin"}, word_valid, 0);
    check({tag, " no_early_done"}, done_seen, 0);
    check({tag, " no_err"}, err_seen, 0);
    if (stall_pct == 0) check({tag, " cycles"}, cyc, n);
    step();
    check({tag, " done_once"}, done, 0);
    $display("run %s mode=%0d words=%0d cycles=%0d", tag, m, got, cyc);
  endtask

  initial begin
    int words;
    int c;
    logic [255:0] rk;
    logic [1:0] rm;

    build_sbox();
    vecs[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 44,
                4, 32'ha0fafe17, 43, 32'hb6630ca6};
    vecs[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 52,
                6, 32'hfe0c91f7, 51, 32'h01002202};
    vecs[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 60,
                8, 32'h9ba35411, 59, 32'h706c631e};

    // Reset state
    repeat (2) step();
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst valid", word_valid, 0);
    check("rst data", word_data, 0);
    check("rst idx", word_idx, 0);
    check("rst done", done, 0);
    check("rst rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Known-answer vectors, ready held high
    for (int v = 0; v < 3; v++) begin
      run_expand(vecs[v].mode, vecs[v].key, 0, 0, $sformatf("kat%0d", v), words);
      check($sformatf("kat%0d count", v), words, vecs[v].n);
      check($sformatf("kat%0d w[%0d]", v, vecs[v].ia), cap_w[vecs[v].ia], vecs[v].ea);
      check($sformatf("kat%0d w[%0d]", v, vecs[v].ib), cap_w[vecs[v].ib], vecs[v].eb);
`ifdef AES_KEY_STORE_EN
      if (vecs[v].mode == 2'd0) begin
        rd_addr = 6'd43;
        step();
        check("store rd[43]", rd_data, 32'hb6630ca6);
        rd_addr = 6'd4;
        step();
        check("store rd[4]", rd_data, 32'ha0fafe17);
        rd_addr = '0;
      end
`else
      check($sformatf("kat%0d rd_data_tied", v), rd_data, 0);
`endif
    end

    // AES-128 with random backpressure; same reference sequence as ready=1
    run_expand(2'd0, vecs[0].key, 40, 0, "stall128", words);

    // start while busy must not disturb the stream
    run_expand(2'd1, vecs[1].key, 0, 1, "poke192", words);

    // Illegal mode
    mode = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    check("mode3 err", err, 1);
    check("mode3 busy", busy, 0);
    check("mode3 valid", word_valid, 0);
    step();
    check("mode3 err_clear", err, 0);
    $display("run reject mode=3");

    // MAX_KEY_BITS=128 instance: AES-256 rejected, AES-128 accepted
    mode128 = 2'd2; start128 = 1'b1;
    step();
    start128 = 1'b0;
    check("max128 err", err128, 1);
    check("max128 busy", busy128, 0);
    step();
    check("max128 err_clear", err128, 0);
    mode128 = 2'd0; start128 = 1'b1;
    step();
    start128 = 1'b0;
    check("max128 legal_busy", busy128, 1);
    check("max128 legal_err", err128, 0);
    c = 0;
    while (!done128 && c < 100) begin step(); c++; end
    check("max128 done_seen", done128, 1);
    $display("run max128 reject=2 accept=0 cycles=%0d", c);

    // Reset mid-run aborts immediately and the next run restarts at w[0]
    mode = 2'd0; key = vecs[0].key; start = 1'b1; word_ready = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (word_idx != 6'd20 && c < 100) begin step(); c++; end
    check("midrst reached20", word_idx, 20);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst valid", word_valid, 0);
    check("midrst data", word_data, 0);
    check("midrst idx", word_idx, 0);
    check("midrst done", done, 0);
    check("midrst rd_data", rd_data, 0);
    word_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("midrst no_done", done, 0);
    check("midrst idle", busy, 0);
    $display("run midreset at_idx=20");
    run_expand(2'd0, vecs[0].key, 0, 0, "after_rst", words);

    // Random keys, modes and backpressure
    for (int r = 0; r < 6; r++) begin
      rm = 2'($urandom_range(0, 2));
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_expand(rm, rk, (r % 2 == 1) ? 30 : 0, 0, $sformatf("rand%0d", r), words);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
- Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256 selected per run by a mode input.
- Parametrised successor to the combinational word-XOR / RotWord / SubWord / Rcon helpers used in key expansion.
- Produces the full expanded schedule (w[0]..w[4*(Nr+1)-1]) as a stream of one 32-bit word per cycle, with valid/ready backpressure.
- Sits between the key-load interface and the round pipeline / round-key store.

Parameters:
- MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256); modes above it are rejected.
- IDX_W, 6, width of word index output; must hold 59.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a new expansion; sampled only in IDLE
- mode  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal
- key  in  256  cipher key, left-aligned; key[255:224] is w[0]; unused LSBs ignored
- busy  out  1  high from accepted start until last word accepted
- err  out  1  one-cycle pulse when start is rejected
- word_valid  out  1  word_data/word_idx valid
- word_ready  in  1  consumer accepts the word when valid & ready
- word_data  out  32  schedule word; [31:24] is byte 0 of the word
- word_idx  out  IDX_W  index i of word_data
- done  out  1  one-cycle pulse in the cycle after the last word is accepted
- rd_addr  in  IDX_W  schedule store read address (optional feature)
- rd_data  out  32  schedule store read data (optional feature)

Behaviour:
- Reset: busy=0, err=0, word_valid=0, word_data=0, word_idx=0, done=0, rd_data=0, FSM in IDLE. Reset mid-run aborts the run immediately; no done is issued.
- FSM states: IDLE, EMIT, FIN.
- IDLE -> EMIT on start with a legal mode. Legal means mode<=2 and the key size is <= MAX_KEY_BITS.
  - Latch key words into an 8x32 window, latch Nk, set i=0, rc=8'h01, rcount=0.
  - First word_valid appears in the next cycle (latency 1).
- start with an illegal mode: err pulses for 1 cycle and the FSM stays IDLE.
- start while busy is ignored, with no err.
- EMIT: for i<Nk, word_data = key word i. For i>=Nk:
  - temp = w[i-1].
  - If i mod Nk==0: temp = SubWord(RotWord(temp)) ^ {rc,24'h0}, where RotWord(x) = {x[23:0],x[31:24]}.
  - Else if Nk==8 and i mod 8==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- Word advance:
  - The word is held stable while word_valid & !word_ready.
  - On acceptance, i increments, the window shifts in w[i], and the next word is valid the following cycle.
  - Sustained throughput is 1 word/cycle with ready held high.
- rc update: after each use, rc = xtime(rc), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 0). The sequence is 01,02,04,...,80,1b,36.
- Counters: a mod-Nk counter (no divider) tracks i mod Nk and wraps at Nk-1; i increments up to 4*(Nr+1)-1, i.e. 43, 51 or 59.
- Termination: acceptance of the last word -> FIN. FIN pulses done, drops busy and word_valid, then -> IDLE. start in FIN is ignored.
- SubWord: 4 parallel S-box lookups, combinational within the cycle.

Optional Feature:
- AES_KEY_STORE_EN defined:
  - Every accepted word is also written into an internal 60x32 array at word_idx.
  - rd_data = array[rd_addr], registered with 1-cycle latency.
  - A read of an address written in the same cycle returns the old value.
  - The array is not reset; rd_data resets to 0.
- Undefined: no array; rd_data is tied to 0 and rd_addr is unused.

Decomposition:
- Package aes_pkg holds:
  - mode enum (AES128, AES192, AES256)
  - Nk/Nr lookup constants
  - SBOX constant, 256x8
  - functions xtime, rot_word, sub_word
  - FSM state typedef
- One sub-module: aes_sub_word (32-bit combinational, 4 S-box instances), reused later by the cipher datapath.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, ready=1:
  - 44 words on consecutive cycles
  - w[4]=a0fafe17, w[43]=b6630ca6
  - done pulses exactly once, one cycle after w[43]
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: w[6]=fe0c91f7, w[51]=01002202; 52 words.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: w[8]=9ba35411, w[59]=706c631e; 60 words; checks the i mod 8==4 SubWord path.
- Random word_ready deasserts during an AES-128 run: word_data/word_idx stay stable while stalled; sequence identical to the ready=1 run.
- Rejection cases:
  - mode=3 -> err pulse, busy stays 0.
  - With MAX_KEY_BITS=128, mode=2 -> err pulse.
  - start during busy -> ignored, stream unchanged.
- Reset and store:
  - rst asserted at word 20 -> all outputs 0 immediately; next start restarts at w[0].
  - With AES_KEY_STORE_EN, after an AES-128 run, rd_addr=43 -> rd_data=b6630ca6 one cycle later.
